// File: rtl/inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_loader_pkg
// Shared constants and types for the instruction-RAM loader:
//   WORDS_MAX   - maximum words per load session (instruction RAM depth)
//   HOLD_CYCLES - cycles IWEN stays high after the last word is presented
//   ADDR_W      - instruction-RAM address width
//   state_e     - loader FSM state encoding
// -----------------------------------------------------------------------------
package inst_loader_pkg;

   localparam int unsigned WORDS_MAX   = 128;
   localparam int unsigned HOLD_CYCLES = 2;
   localparam int unsigned ADDR_W      = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2,
      FIN  = 2'd3
   } state_e;

endpackage : inst_loader_pkg

// File: rtl/inst_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles a host byte stream into 32-bit big-endian words.
// Ports:
//   clk         - clock
//   rst         - synchronous active-high reset
//   clr_i       - synchronous clear at the start of a session
//   accept_i    - a byte is accepted on this edge
//   byte_i      - byte being accepted
//   word_o      - complete word (valid while word_done_o is high)
//   word_done_o - strobe: this edge accepts the 4th byte of a word
// -----------------------------------------------------------------------------
module byte_packer
   import inst_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);

   logic [31:0] shadow_q, shadow_d;
   logic [1:0]  cnt_q,    cnt_d;
   logic [31:0] merged;

   // Shadow with the incoming byte dropped into its big-endian lane; on the
   // 4th byte this is the finished word, so it can be presented on the same
   // edge that accepts that byte.
   always_comb begin
      unique case (cnt_q)
         2'd0:    merged = {byte_i, shadow_q[23:0]};
         2'd1:    merged = {shadow_q[31:24], byte_i, shadow_q[15:0]};
         2'd2:    merged = {shadow_q[31:16], byte_i, shadow_q[7:0]};
         default: merged = {shadow_q[31:8], byte_i};
      endcase
   end

   assign word_o      = merged;
   assign word_done_o = accept_i && (cnt_q == 2'd3);

   // NOTE: every variable assigned in an always_comb gets a default first so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      if (clr_i) begin
         shadow_d = '0;
         cnt_d    = '0;
      end else if (accept_i) begin
         cnt_d    = cnt_q + 2'd1;
         shadow_d = word_done_o ? '0 : merged;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         cnt_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule : byte_packer

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Loads a host byte stream into the chip's instruction RAM, one 32-bit word
// per 4 bytes, then holds the load enable for HOLD_CYCLES before finishing.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - one-cycle pulse that begins a session (ignored while busy)
//   word_count - words to load, sampled on the start cycle
//   rx_data    - host byte; rx_valid qualifies it; rx_ready high only in LOAD
//   IWEN       - instruction-RAM load enable
//   I_Addr     - instruction-RAM word address
//   wInst      - instruction word
//   busy       - session in progress
//   done       - one-cycle completion pulse
//   err        - sticky illegal word_count flag
// -----------------------------------------------------------------------------
module inst_loader #(
   parameter int unsigned WORDS_MAX   = inst_loader_pkg::WORDS_MAX,
   parameter int unsigned HOLD_CYCLES = inst_loader_pkg::HOLD_CYCLES
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [7:0]                         word_count,
   input  logic [7:0]                         rx_data,
   input  logic                               rx_valid,
   output logic                               rx_ready,
   output logic                               IWEN,
   output logic [inst_loader_pkg::ADDR_W-1:0] I_Addr,
   output logic [31:0]                        wInst,
   output logic                               busy,
   output logic                               done,
   output logic                               err
);

   import inst_loader_pkg::*;

   localparam logic [7:0] MAX_CNT   = 8'(WORDS_MAX);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_e              state_q,    state_d;
   logic                iwen_q,     iwen_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;
   logic                err_q,      err_d;
   logic [ADDR_W-1:0]   iaddr_q,    iaddr_d;
   logic [31:0]         winst_q,    winst_d;
   logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
   logic [ADDR_W-1:0]   last_idx_q, last_idx_d;
   logic [7:0]          hold_cnt_q, hold_cnt_d;

   logic                pk_clr;
   logic                pk_accept;
   logic [31:0]         pk_word;
   logic                pk_word_done;
   logic                count_ok;

   assign rx_ready  = (state_q == LOAD);
   assign pk_accept = rx_valid && rx_ready;
   assign count_ok  = (word_count != 8'd0) && (word_count <= MAX_CNT);

   byte_packer u_byte_packer (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (pk_clr),
      .accept_i    (pk_accept),
      .byte_i      (rx_data),
      .word_o      (pk_word),
      .word_done_o (pk_word_done)
   );

   always_comb begin
      state_d    = state_q;
      iwen_d     = iwen_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      iaddr_d    = iaddr_q;
      winst_d    = winst_q;
      word_idx_d = word_idx_q;
      last_idx_d = last_idx_q;
      hold_cnt_d = hold_cnt_q;
      pk_clr     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (count_ok) begin
                  state_d    = LOAD;
                  iwen_d     = 1'b1;
                  busy_d     = 1'b1;
                  err_d      = 1'b0;
                  word_idx_d = '0;
                  // count_ok bounds word_count to 1..WORDS_MAX, so the last
                  // index always fits the address width.
                  last_idx_d = ADDR_W'(word_count - 8'd1);
                  hold_cnt_d = '0;
                  pk_clr     = 1'b1;
               end else begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
            end
         end

         LOAD: begin
            if (pk_word_done) begin
               iaddr_d    = word_idx_q;
               winst_d    = pk_word;
               word_idx_d = word_idx_q + 1'b1;
               if (word_idx_q == last_idx_q) begin
                  state_d    = HOLD;
                  hold_cnt_d = '0;
               end
            end
         end

         HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = FIN;
               iwen_d  = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         iwen_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         iaddr_q    <= '0;
         winst_q    <= '0;
         word_idx_q <= '0;
         last_idx_q <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         iwen_q     <= iwen_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         iaddr_q    <= iaddr_d;
         winst_q    <= winst_d;
         word_idx_q <= word_idx_d;
         last_idx_q <= last_idx_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign IWEN   = iwen_q;
   assign I_Addr = iaddr_q;
   assign wInst  = winst_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule : inst_loader

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter WORDS_MAX, 128, max words per session (instruction RAM depth).
REQ-002 SHALL have parameter HOLD_CYCLES, 2, cycles IWEN stays high after the last word is presented.
REQ-003 SHALL have port clk  input  1  the single clock; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a load session.
REQ-006 SHALL have port word_count  input  8  words to load, sampled on the start cycle.
REQ-007 SHALL have port rx_data  input  8  host byte stream.
REQ-008 SHALL have port rx_valid  input  1  rx_data valid.
REQ-009 SHALL have port rx_ready  output  1  byte accepted when rx_valid and rx_ready are both 1 on a clk edge.
REQ-010 SHALL have port IWEN  output  1  instruction-RAM load enable toward the chip.
REQ-011 SHALL have port I_Addr  output  7  instruction-RAM word address.
REQ-012 SHALL have port wInst  output  32  instruction word.
REQ-013 SHALL have port busy  output  1  high from the cycle after start until the done cycle.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err  output  1  sticky illegal-count flag, cleared by the next accepted start.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, HOLD, FIN.
REQ-017 IDLE: on start with 1<=word_count<=WORDS_MAX -> LOAD next cycle; IWEN=1, busy=1, err=0, word/byte counters=0.
REQ-018 IDLE: on start with word_count=0 or >WORDS_MAX -> stay IDLE; err=1 and done=1 in the following cycle; IWEN never asserted.
REQ-019 rx_ready SHALL be 1 only in LOAD; bytes are never accepted in any other state.
REQ-020 Bytes SHALL be packed big-endian into a shadow register: first byte of a word -> bits [31:24], fourth -> [7:0].
REQ-021 On the edge accepting a word's 4th byte, wInst and I_Addr SHALL update in the same edge: wInst=shadow word, I_Addr=word index (0 for the first word, +1 per subsequent word).
REQ-022 wInst and I_Addr SHALL NOT change at any other time during a session, so every cycle with IWEN=1 writes a complete word only.
REQ-023 After the word_count-th word is presented, LOAD -> HOLD; IWEN stays 1 for exactly HOLD_CYCLES cycles, then HOLD -> FIN.
REQ-024 FIN: IWEN=0, busy=0, done=1 for one cycle -> IDLE.
REQ-025 start while busy SHALL be ignored; word_count is not resampled.
REQ-026 I_Addr SHALL never wrap: WORDS_MAX words end at address WORDS_MAX-1.
REQ-027 rx_valid gaps of any length SHALL stall packing without side effects; IWEN stays 1 throughout LOAD.
REQ-028 IWEN high time per session SHALL be at least 3 cycles.

Reset
REQ-029 When rst=1 on a clk edge, all outputs SHALL be 0 from the next cycle: IWEN, I_Addr, wInst, rx_ready, busy, done, err; state=IDLE; shadow and counters cleared.
REQ-030 Reset mid-session SHALL abort immediately; a partially packed word is discarded and never presented.

Structure
REQ-031 Shared package inst_loader_pkg SHALL hold the state enumeration, WORDS_MAX, HOLD_CYCLES, and the 7-bit address width constant.
REQ-032 Byte-to-word assembly (shadow register, 2-bit byte counter, word-complete strobe) SHALL be the single sub-module byte_packer.

Verification
REQ-033 start, word_count=1, bytes 0x13,0x00,0x00,0x00 -> I_Addr=0, wInst=0x13000000, IWEN high through 2 HOLD cycles, then done pulse, busy=0.
REQ-034 word_count=3, 12 bytes with random rx_valid gaps -> words at addresses 0,1,2 in order; I_Addr/wInst change only on 4th-byte edges.
REQ-035 word_count=0, and separately 129 -> err=1 and done=1 one cycle after start, IWEN stays 0, rx_ready stays 0.
REQ-036 rst asserted after 2 bytes of word 1 -> next cycle IWEN=0, rx_ready=0, all outputs 0; a new session then loads from address 0.
REQ-037 word_count=128 -> final I_Addr=127, no wrap; start pulses issued mid-session are ignored.
